// File: rtl/process_joiner_if.sv
// process_joiner_if
// Bundles the scheduler request/response signals, the free-request return and
// both stack RAM ports of the process joiner.
//   slave  : the joiner side (drives results, RAM addresses/write data, freeRequest)
//   master : the scheduler/RAM side (drives the request, pids, word count and RAM read data)
// Handshake: the joiner samples enabled in IDLE; once the join has ended,
// finished (and error on an aborted join) stays high until enabled is seen low.
// RAM ports are synchronous-read: read data is valid one cycle after the address,
// and a write happens on the rising edge while readWrite=1.
interface process_joiner_if #(
    parameter int addrBits = 8,
    parameter int dataBits = 16
);
    logic                enabled;
    logic                finished;
    logic                error;
    logic [addrBits-1:0] childPid;
    logic [addrBits-1:0] parentPid;
    logic [addrBits-1:0] wordsToReturn;
    logic [4:0]          childCell;
    logic [4:0]          parentCell;
    logic [addrBits-1:0] addressForChildStack;
    logic [dataBits-1:0] dataOutForChildStack;
    logic [dataBits-1:0] dataInForChildStack;
    logic                readWriteForChildStack;
    logic [addrBits-1:0] addressForParentStack;
    logic [dataBits-1:0] dataOutForParentStack;
    logic [dataBits-1:0] dataInForParentStack;
    logic                readWriteForParentStack;
    logic                freeRequest;
    logic [addrBits-1:0] freePid;

    modport slave (
        input  enabled, childPid, parentPid, wordsToReturn,
        input  dataOutForChildStack, dataOutForParentStack,
        output finished, error, childCell, parentCell,
        output addressForChildStack, dataInForChildStack, readWriteForChildStack,
        output addressForParentStack, dataInForParentStack, readWriteForParentStack,
        output freeRequest, freePid
    );

    modport master (
        output enabled, childPid, parentPid, wordsToReturn,
        output dataOutForChildStack, dataOutForParentStack,
        input  finished, error, childCell, parentCell,
        input  addressForChildStack, dataInForChildStack, readWriteForChildStack,
        input  addressForParentStack, dataInForParentStack, readWriteForParentStack,
        input  freeRequest, freePid
    );
endinterface

// File: rtl/process_joiner.sv
// process_joiner
// Return path of a terminating child process: pops wordsToReturn result words off
// the child stack, pushes them onto the parent stack in the same order, rewrites
// both stack headers (word 0, SP in the top addrBits bits, low bits preserved)
// and pulses freeRequest for the child pid.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous, active-low
//   bus      : process_joiner_if.slave (request, result, RAM ports, free request)
//   stateDbg : current FSM state encoding, for observation only
// Optional feature: define JOIN_OVERFLOW_CHECK_EN to abort (ERROR state) when the
// child holds fewer than N words or the parent would exceed 255 words. Without it
// error is tied low and stack pointers wrap silently.
module process_joiner #(
    parameter int addrBits = 8,
    parameter int dataBits = 16
) (
    input  logic            clk,
    input  logic            reset,
    process_joiner_if.slave bus,
    output logic [2:0]      stateDbg
);
    localparam int lowBits = dataBits - addrBits;
    localparam logic [addrBits-1:0] oneAddr = {{(addrBits-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        RD_CHILD_HDR  = 3'd1,
        RD_PARENT_HDR = 3'd2,
        CHECK         = 3'd3,
        COPY          = 3'd4,
        WR_HDRS       = 3'd5,
        DONE          = 3'd6,
        ERROR         = 3'd7
    } joinStateT;

    joinStateT state, nextState;

    logic [addrBits-1:0] childPidQ, parentPidQ, nQ;
    logic [addrBits-1:0] childSpQ, newChildSpQ, newParentSpQ;
    logic [lowBits-1:0]  childLowQ, parentLowQ;
    logic [addrBits-1:0] copyCnt;
    logic [addrBits-1:0] childAddrQ, parentAddrQ;

    // Parent header is on the read port during CHECK; SP math uses it directly.
    logic [addrBits-1:0] parentSpIn, newParentSpC, newChildSpC;
    assign parentSpIn   = bus.dataOutForParentStack[dataBits-1 -: addrBits];
    assign newParentSpC = parentSpIn - nQ;
    assign newChildSpC  = childSpQ + nQ;

    logic overflow;
`ifdef JOIN_OVERFLOW_CHECK_EN
    // Depth of a down-growing stack from 0x100: (0 - SP) mod 2^addrBits.
    logic [addrBits-1:0] childDepth, parentDepth;
    logic [addrBits:0]   parentSum;
    assign childDepth  = '0 - childSpQ;
    assign parentDepth = '0 - parentSpIn;
    assign parentSum   = {1'b0, parentDepth} + {1'b0, nQ};
    assign overflow    = (nQ > childDepth) || (parentSum > {1'b0, {addrBits{1'b1}}});
`else
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:          if (bus.enabled) nextState = RD_CHILD_HDR;
            RD_CHILD_HDR:  nextState = RD_PARENT_HDR;
            RD_PARENT_HDR: nextState = CHECK;
            CHECK: begin
                if (overflow)        nextState = ERROR;
                else if (nQ == '0)   nextState = WR_HDRS;
                else                 nextState = COPY;
            end
            COPY:          if (copyCnt == nQ) nextState = WR_HDRS;
            WR_HDRS:       nextState = DONE;
            DONE, ERROR:   if (!bus.enabled) nextState = IDLE;
            default:       nextState = IDLE;
        endcase
    end

    // Datapath registers. In COPY cycle k the child address is childSp+k and the
    // parent address is newParentSp+k-1, so the word read in cycle k lands in
    // the parent during cycle k+1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            childPidQ    <= '0;
            parentPidQ   <= '0;
            nQ           <= '0;
            childSpQ     <= '0;
            childLowQ    <= '0;
            parentLowQ   <= '0;
            newChildSpQ  <= '0;
            newParentSpQ <= '0;
            copyCnt      <= '0;
            childAddrQ   <= '0;
            parentAddrQ  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.enabled) begin
                        childPidQ   <= bus.childPid;
                        parentPidQ  <= bus.parentPid;
                        nQ          <= bus.wordsToReturn;
                        childAddrQ  <= '0;
                        parentAddrQ <= '0;
                    end
                end
                RD_PARENT_HDR: begin
                    childSpQ  <= bus.dataOutForChildStack[dataBits-1 -: addrBits];
                    childLowQ <= bus.dataOutForChildStack[lowBits-1:0];
                end
                CHECK: begin
                    parentLowQ   <= bus.dataOutForParentStack[lowBits-1:0];
                    newParentSpQ <= newParentSpC;
                    newChildSpQ  <= newChildSpC;
                    copyCnt      <= '0;
                    if (nextState == COPY) begin
                        childAddrQ  <= childSpQ;
                        parentAddrQ <= newParentSpC;
                    end else begin
                        childAddrQ  <= '0;
                        parentAddrQ <= '0;
                    end
                end
                COPY: begin
                    copyCnt <= copyCnt + oneAddr;
                    if (copyCnt == nQ) begin
                        childAddrQ  <= '0;
                        parentAddrQ <= '0;
                    end else begin
                        childAddrQ  <= childAddrQ + oneAddr;
                        parentAddrQ <= newParentSpQ + copyCnt;
                    end
                end
                default: ;
            endcase
        end
    end

    logic copyWrite;
    assign copyWrite = (state == COPY) && (copyCnt != '0);

    assign bus.finished                = (state == DONE) || (state == ERROR);
`ifdef JOIN_OVERFLOW_CHECK_EN
    assign bus.error                   = (state == ERROR);
`else
    assign bus.error                   = 1'b0;
`endif
    assign bus.childCell               = childPidQ[4:0];
    assign bus.parentCell              = parentPidQ[4:0];
    assign bus.addressForChildStack    = childAddrQ;
    assign bus.addressForParentStack   = parentAddrQ;
    assign bus.readWriteForChildStack  = (state == WR_HDRS);
    assign bus.readWriteForParentStack = (state == WR_HDRS) || copyWrite;
    assign bus.dataInForChildStack     = (state == WR_HDRS) ? {newChildSpQ, childLowQ} : '0;
    // Copied words go straight from the child read port to the parent write port.
    assign bus.dataInForParentStack    = copyWrite            ? bus.dataOutForChildStack :
                                         (state == WR_HDRS)   ? {newParentSpQ, parentLowQ} : '0;
    assign bus.freeRequest             = (state == WR_HDRS);
    assign bus.freePid                 = childPidQ;
    assign stateDbg                    = state;

    // Only the low five pid bits select a memory cell.
    logic unusedPidBits;
    assign unusedPidBits = &{1'b0, childPidQ[addrBits-1:5], parentPidQ[addrBits-1:5]};
endmodule
